// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
//
// Adds two W-bit operands (W = 32*NWORDS) plus a carry-in by sequencing them
// one 32-bit word at a time through an external 32-bit adder.
// Word 0 (bits [31:0]) is processed first. The carry ripples through
// carry_q between words.
//
// Ports
//   clk, rst_n          : clock; asynchronous active-low reset
//   in_valid / in_ready : operand request handshake (accepted only in IDLE)
//   op_a, op_b, op_cin  : W-bit operands and carry-in to word 0
//   add_a, add_b, add_c : word and carry presented to the external adder
//                         (zero outside RUN)
//   add_sum, add_cout   : combinational result from the external adder
//   out_valid/out_ready : result handshake (out_valid high in DONE)
//   out_sum, out_cout   : full-width result. It holds its value until the
//                         next operation overwrites it word by word.
//   busy                : high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int NWORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*NWORDS-1:0]  op_a,
    input  logic [32*NWORDS-1:0]  op_b,
    input  logic                  op_cin,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_c,
    input  logic [31:0]           add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NWORDS-1:0]  out_sum,
    output logic                  out_cout,
    output logic                  busy
);

    // Keep the index at least one bit wide so that NWORDS = 1 is still legal.
    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NWORDS-1:0][31:0]  a_q, a_d;
    logic [NWORDS-1:0][31:0]  b_q, b_d;
    logic [NWORDS-1:0][31:0]  sum_q, sum_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic                     carry_q, carry_d;
    logic                     cout_q, cout_d;

    // Next-state logic.
    // The result register is written in place, one word per RUN cycle.
    // This means out_sum keeps showing the previous result until the new
    // words overwrite it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = add_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state lives here.
    // Reset clears the sequencing state and the visible result, so any
    // operation in flight is abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // All outputs decode directly from registers.
    // Because of that, nothing here combinationally depends on the external
    // adder or on the handshake inputs.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign add_a     = (state_q == RUN) ? a_q[idx_q] : 32'd0;
    assign add_b     = (state_q == RUN) ? b_q[idx_q] : 32'd0;
    assign add_c     = (state_q == RUN) ? carry_q    : 1'b0;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have parameter NWORDS, default 2, giving the number of 32-bit words per operand (operand width W = 32*NWORDS, NWORDS >= 1).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept an operand request.
REQ-006 op_a  input  W  operand A, word 0 = bits [31:0].
REQ-007 op_b  input  W  operand B.
REQ-008 op_cin  input  1  carry-in to word 0.
REQ-009 add_a  output  32  A word driven to the external 32-bit adder.
REQ-010 add_b  output  32  B word driven to the external 32-bit adder.
REQ-011 add_c  output  1  carry driven to the external 32-bit adder.
REQ-012 add_sum  input  32  sum returned by the external adder (combinational in add_a/add_b/add_c).
REQ-013 add_cout  input  1  carry-out returned by the external adder.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_sum  output  W  full-width sum.
REQ-017 out_cout  output  1  carry-out of the top word.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; in_ready SHALL be 0 in DONE even while out_ready is 1 (no same-cycle overlap).
REQ-021 In IDLE with in_valid=1 at a rising edge, the block SHALL register op_a, op_b, set carry register = op_cin, word index = 0, and go to RUN.
REQ-022 In RUN, add_a/add_b SHALL be word[index] of the registered operands and add_c SHALL be the carry register; outside RUN, add_a, add_b, add_c SHALL be 0.
REQ-023 At each RUN edge the block SHALL store add_sum into result word[index], load carry register with add_cout, and increment index.
REQ-024 At the RUN edge where index = NWORDS-1 the block SHALL go to DONE with out_cout = add_cout of that edge.
REQ-025 Latency: request accepted at edge k SHALL give out_valid = 1 after edge k+NWORDS.
REQ-026 In DONE, out_valid SHALL be 1 and out_sum/out_cout SHALL remain stable until out_valid && out_ready at an edge, which SHALL return the FSM to IDLE.
REQ-027 out_sum/out_cout SHALL hold the last result after returning to IDLE until the next result overwrites them word by word.
REQ-028 in_valid and operand inputs SHALL be ignored in RUN and DONE; operand input changes after acceptance SHALL not affect the result.
REQ-029 Arithmetic SHALL be unsigned modulo 2^W with carry-out, i.e. {out_cout, out_sum} = op_a + op_b + op_cin.

Reset
REQ-030 rst_n = 0 SHALL immediately, without a clock, force IDLE, index 0, carry register 0, out_sum 0, out_cout 0, out_valid 0, busy 0, add_a/add_b/add_c 0; in_ready SHALL be 1 while rst_n = 0 deasserted only by FSM state rules.
REQ-031 Reset asserted in RUN or DONE SHALL abandon the operation; no out_valid pulse SHALL follow release.

Verification (NWORDS = 2, external adder a true 32-bit adder)
REQ-032 Reset: rst_n=0 mid-cycle -> all outputs 0 at once, in_ready = 1 after release, busy = 0.
REQ-033 Basic: op_a=1, op_b=0, op_cin=0 accepted at edge k -> out_valid after k+2, out_sum=0x0000000000000001, out_cout=0.
REQ-034 Inter-word carry: op_a=0x00000000FFFFFFFF, op_b=0x1, op_cin=0 -> out_sum=0x0000000100000000, out_cout=0; add_c=1 during second RUN cycle.
REQ-035 Full overflow: op_a=0xFFFFFFFFFFFFFFFF, op_b=0, op_cin=1 -> out_sum=0, out_cout=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing operands -> out_sum/out_cout stable, in_ready=0, no new capture; out_ready=1 -> IDLE next edge.
REQ-037 Reset in RUN: rst_n pulsed low after first RUN edge -> IDLE, out_sum=0, no out_valid afterward; a following request 0x3A+0x57 yields out_sum=0x91.
